// File: rtl/zap_dbus_ctrl_if.sv
// Data-side Wishbone port of zap_dbus_ctrl: the controller owns the master
// modport, the external memory/slave the slave modport.
interface zap_dbus_ctrl_if;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        o_wb_we;
  logic [31:0] o_wb_adr;
  logic [31:0] o_wb_dat;
  logic [3:0]  o_wb_sel;
  logic        i_wb_ack;
  logic        i_wb_err;
  logic [31:0] i_wb_dat;

  modport master (
    output o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    input  i_wb_ack, i_wb_err, i_wb_dat
  );

  modport slave (
    input  o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_dat, o_wb_sel,
    output i_wb_ack, i_wb_err, i_wb_dat
  );
endinterface

// File: rtl/zap_dbus_ctrl.sv
// Data-bus sequencer: one classic Wishbone cycle per memory micro-op, with
// stall/fault generation. Optional WAIT timeout enabled by ZAP_DBUS_TIMEOUT_EN.
module zap_dbus_ctrl #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd256
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_clear_from_writeback,
  input  logic                   i_cyc,
  input  logic                   i_stb,
  input  logic                   i_we,
  input  logic [31:0]            i_adr,
  input  logic [31:0]            i_dat,
  input  logic [3:0]             i_sel,
  zap_dbus_ctrl_if.master        wb,
  output logic                   o_data_stall,
  output logic                   o_data_mem_fault,
  output logic [31:0]            o_rd_data,
  output logic                   o_rd_valid,
  output logic [1:0]             o_state
);

  // Handshake: a request (i_cyc & i_stb) is taken only in IDLE; o_data_stall is
  // the back-pressure, the pipeline holds its request register while it is high.
  // A bus cycle ends on the first i_wb_ack/i_wb_err seen while o_wb_cyc is high.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_FAULT = 2'd2
  } state_t;

  state_t state;
  logic   req;
  logic   timeout_hit;

  assign req     = i_cyc & i_stb;
  assign o_state = state;

`ifdef ZAP_DBUS_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 32'd1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TIMER_LAST = CW'(TIMEOUT_CYCLES - 32'd1);

  logic [CW-1:0] timer;

  // Held at zero outside WAIT, so it is already cleared on WAIT entry.
  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear_from_writeback || (state != S_WAIT)) begin
      timer <= '0;
    end else if (!(wb.i_wb_ack || wb.i_wb_err)) begin
      timer <= timer + CW'(1);
    end
  end

  assign timeout_hit = (state == S_WAIT) && (timer == TIMER_LAST);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign timeout_hit        = 1'b0;
`endif

  always_comb begin
    o_data_stall = 1'b0;
    if (!i_reset && !i_clear_from_writeback) begin
      case (state)
        S_IDLE:  o_data_stall = req;
        S_WAIT:  o_data_stall = ~(wb.i_wb_ack | wb.i_wb_err | timeout_hit);
        default: o_data_stall = 1'b0;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state            <= S_IDLE;
      wb.o_wb_cyc      <= 1'b0;
      wb.o_wb_stb      <= 1'b0;
      wb.o_wb_we       <= 1'b0;
      wb.o_wb_adr      <= 32'd0;
      wb.o_wb_dat      <= 32'd0;
      wb.o_wb_sel      <= 4'd0;
      o_data_mem_fault <= 1'b0;
      o_rd_valid       <= 1'b0;
      o_rd_data        <= 32'd0;
    end else begin
      o_data_mem_fault <= 1'b0;
      o_rd_valid       <= 1'b0;
      if (i_clear_from_writeback) begin
        wb.o_wb_cyc <= 1'b0;
        wb.o_wb_stb <= 1'b0;
        state       <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (req) begin
              wb.o_wb_cyc <= 1'b1;
              wb.o_wb_stb <= 1'b1;
              wb.o_wb_we  <= i_we;
              wb.o_wb_adr <= {i_adr[31:2], 2'b00};
              wb.o_wb_dat <= i_dat;
              wb.o_wb_sel <= i_sel;
              state       <= S_WAIT;
            end
          end
          S_WAIT: begin
            // Error beats a simultaneous ack; ack beats a timeout in the same cycle.
            if (wb.i_wb_err || (timeout_hit && !wb.i_wb_ack)) begin
              wb.o_wb_cyc      <= 1'b0;
              wb.o_wb_stb      <= 1'b0;
              o_data_mem_fault <= 1'b1;
              state            <= S_FAULT;
            end else if (wb.i_wb_ack) begin
              wb.o_wb_cyc <= 1'b0;
              wb.o_wb_stb <= 1'b0;
              if (!wb.o_wb_we) begin
                o_rd_data  <= wb.i_wb_dat;
                o_rd_valid <= 1'b1;
              end
              state <= S_IDLE;
            end
          end
          S_FAULT: begin
            state <= S_FAULT;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/zap_dbus_ctrl.md
Name: zap_dbus_ctrl

Overview:
- Data-bus sequencer between the post-ALU stage's registered Wishbone request fields and the external data Wishbone port.
- Issues one classic Wishbone cycle per memory micro-op and generates the data-stall and data-memory-fault signals that hold the pipeline.
- Returns read data plus a one-cycle valid to the writeback path.
- Sole owner of the data bus; the pipeline never drives the bus directly.

Parameters:
- TIMEOUT_CYCLES, 32'd256, cycles in WAIT without ack/err before a forced fault (used only with ZAP_DBUS_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock.
- i_reset  in  1  synchronous active-high reset.
- i_clear_from_writeback  in  1  pipeline flush; abandons the current access.
- i_cyc  in  1  request cycle from the post-ALU stage register.
- i_stb  in  1  request strobe from the post-ALU stage register.
- i_we  in  1  1 = store.
- i_adr  in  32  byte address.
- i_dat  in  32  store data.
- i_sel  in  4  byte lanes.
- o_wb_cyc  out  1  Wishbone cycle.
- o_wb_stb  out  1  Wishbone strobe.
- o_wb_we  out  1  Wishbone write enable.
- o_wb_adr  out  32  Wishbone address; bits[1:0] forced 0.
- o_wb_dat  out  32  Wishbone write data.
- o_wb_sel  out  4  Wishbone byte select.
- i_wb_ack  in  1  Wishbone acknowledge.
- i_wb_err  in  1  Wishbone error.
- i_wb_dat  in  32  Wishbone read data.
- o_data_stall  out  1  hold pipeline (combinational).
- o_data_mem_fault  out  1  one-cycle fault pulse (registered).
- o_rd_data  out  32  captured read data.
- o_rd_valid  out  1  one-cycle pulse when o_rd_data is updated by a load.

Behaviour:
- Reset: state=IDLE; o_wb_cyc/stb/we=0; o_wb_adr/dat=0; o_wb_sel=0; o_data_mem_fault=0; o_rd_valid=0; o_rd_data=0; timeout counter=0.
- Priority order: i_reset > i_clear_from_writeback > bus events.
- IDLE:
  - Condition req = i_cyc & i_stb.
  - If req: register i_we/i_adr/i_dat/i_sel onto the bus outputs, set o_wb_cyc=o_wb_stb=1 next cycle, go WAIT.
  - o_data_stall=1 in that same cycle.
- WAIT:
  - Outputs held stable; o_data_stall = ~(i_wb_ack | i_wb_err).
  - On i_wb_ack: deassert cyc/stb next cycle, go IDLE. If ~we, o_rd_data<=i_wb_dat and o_rd_valid=1 for one cycle.
  - On i_wb_err: deassert cyc/stb, o_data_mem_fault=1 for one cycle, go FAULT.
  - ack and err together: err wins; no read data is captured.
- FAULT:
  - o_data_stall=0.
  - New requests are ignored; the stage sleeps after a fault.
  - Remain in FAULT until i_clear_from_writeback, then go IDLE.
- i_clear_from_writeback in any state:
  - Next cycle: cyc/stb=0, state=IDLE, pulses cleared, counter=0.
  - o_data_stall=0 in the clear cycle.
  - A late ack/err arriving after the abort (cyc=0) is ignored.
- Throughput and latency:
  - Minimum 2 cycles per access: issue cycle, then ack seen in WAIT.
  - o_data_stall is low in the ack cycle; the next request is sampled the following cycle; no back-to-back overlap.
  - Zero-wait slave: o_rd_valid is high 2 cycles after req is first seen.
- Bus protocol: a request with i_cyc=1, i_stb=0 issues nothing. Bus outputs never change while in WAIT.

Optional Feature:
- Macro: ZAP_DBUS_TIMEOUT_EN.
- Defined:
  - A $clog2(TIMEOUT_CYCLES)-bit counter clears on WAIT entry and increments each WAIT cycle without ack/err.
  - When it reaches TIMEOUT_CYCLES-1 with no ack/err, the block behaves exactly as i_wb_err (fault pulse, FAULT state).
  - An ack arriving in the timeout cycle wins.
- Undefined: no counter is instantiated; WAIT lasts until ack/err or clear.

Test Plan:
- Load, zero-wait: adr=0x100, we=0, slave acks first WAIT cycle with dat=0xDEADBEEF -> o_wb_cyc high 1 cycle; o_rd_data=0xDEADBEEF; o_rd_valid pulses once; stall high exactly 1 cycle.
- Store, 3 wait states: adr=0x204, dat=0x11223344, sel=4'b1111, ack on 4th WAIT cycle -> bus outputs stable 4 cycles, o_wb_adr=0x204; stall high 4 cycles; o_rd_valid stays 0.
- Error: load with i_wb_err on 2nd WAIT cycle -> o_data_mem_fault pulses 1 cycle; FAULT entered; following req ignored (cyc stays 0) until clear, then next req issues.
- Flush mid-access: clear asserted on 2nd WAIT cycle, slave acks 1 cycle later -> cyc=0 after clear; no o_rd_valid; state IDLE.
- Reset mid-access: i_reset during WAIT -> next cycle all outputs at reset values; subsequent ack ignored.
- With ZAP_DBUS_TIMEOUT_EN and TIMEOUT_CYCLES=8: no ack -> fault pulse after exactly 8 WAIT cycles. Without the macro: cyc remains high indefinitely (checked for 1000 cycles).
